// File: rtl/xtea_pkg.sv
// Constants, state encoding and helpers shared by the XTEA demo system.
// Plaintext/key ROMs are fixed byte tables read MSB first during LOAD.
package xtea_pkg;
   localparam int          ROUNDS_DEF = 32;
   localparam logic [31:0] DELTA      = 32'h9E3779B9;
   localparam int          MEM3_DEPTH = 8;
   localparam int          LOAD_BYTES = 24;

   typedef enum logic [2:0] {IDLE, LOAD, ENC, WRITE, DONE} state_t;

   localparam logic [7:0] PLAINTEXT [8] = '{8'h11, 8'h22, 8'h33, 8'h44,
                                            8'h55, 8'h66, 8'h77, 8'h88};
   localparam logic [7:0] KEY [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                                       8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};

   // Load index 0..7 selects plaintext, 8..23 selects key bytes.
   function automatic logic [7:0] rom_byte(input logic [4:0] idx);
      logic [4:0] kidx;
      kidx = idx - 5'd8;
      if (idx < 5'd8) return PLAINTEXT[idx[2:0]];
      else            return KEY[kidx[3:0]];
   endfunction

   function automatic logic [31:0] key_word(input logic [127:0] key, input logic [1:0] idx);
      case (idx)
         2'd0: return key[127:96];
         2'd1: return key[95:64];
         2'd2: return key[63:32];
         2'd3: return key[31:0];
      endcase
   endfunction

   function automatic logic [7:0] sel_byte(input logic [63:0] d, input logic [2:0] i);
      logic [63:0] s;
      s = d << {i, 3'b000};
      return s[63:56];
   endfunction
endpackage

// File: rtl/xtea_byte_ram.sv
// Byte-wide result RAM: synchronous write, combinational/hierarchical read.
// Asynchronous reset clears every entry so no partial result survives an abort.
module xtea_byte_ram
   import xtea_pkg::*;
#(
   parameter int DEPTH = MEM3_DEPTH,
   parameter int AW    = $clog2(DEPTH)
)(
   input logic          clk,
   input logic          rst,
   input logic          we_i,
   input logic [AW-1:0] addr_i,
   input logic [7:0]    dat_i
);
   logic [7:0] ram [0:DEPTH-1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) ram[i] <= 8'h00;
      end else if (we_i) begin
         ram[addr_i] <= dat_i;
      end
   end
endmodule

// File: rtl/xtea_round.sv
// One full XTEA cycle (both half-rounds), purely combinational.
// The second half-round uses the updated v0 and sum from the first.
module xtea_round
   import xtea_pkg::*;
(
   input  logic [31:0]  v0_i,
   input  logic [31:0]  v1_i,
   input  logic [31:0]  sum_i,
   input  logic [127:0] key_i,
   output logic [31:0]  v0_o,
   output logic [31:0]  v1_o,
   output logic [31:0]  sum_o
);
   function automatic logic [31:0] mix(input logic [31:0] x);
      return ((x << 4) ^ (x >> 5)) + x;
   endfunction

   assign v0_o  = v0_i + (mix(v1_i) ^ (sum_i + key_word(key_i, sum_i[1:0])));
   assign sum_o = sum_i + DELTA;
   assign v1_o  = v1_i + (mix(v0_o) ^ (sum_o + key_word(key_i, sum_o[12:11])));
endmodule

// File: rtl/xtea_system_top.sv
// XTEA demo: load ROM plaintext/key, encrypt, write 8 ciphertext bytes to ram_mem3.
// Reset release to last RAM write takes 1 + 24 + ROUNDS + 8 clock cycles.
module xtea_system_top
   import xtea_pkg::*;
#(
   parameter int ROUNDS = ROUNDS_DEF
)(
   input logic clk,
   input logic rst
);
   state_t       state_q;
   logic [7:0]   cnt_q;
   logic [31:0]  v0_q, v1_q, sum_q;
   logic [127:0] key_q;
   logic [31:0]  v0_d, v1_d, sum_d;
   logic [7:0]   ld_byte;

   logic         p2_write_strobe;
   logic [7:0]   p2_port_id;
   logic [7:0]   p2_out_port;

   assign ld_byte = rom_byte(cnt_q[4:0]);

   xtea_round u_round (
      .v0_i  (v0_q),
      .v1_i  (v1_q),
      .sum_i (sum_q),
      .key_i (key_q),
      .v0_o  (v0_d),
      .v1_o  (v1_d),
      .sum_o (sum_d)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= IDLE;
         cnt_q           <= 8'd0;
         v0_q            <= 32'd0;
         v1_q            <= 32'd0;
         sum_q           <= 32'd0;
         key_q           <= 128'd0;
         p2_write_strobe <= 1'b0;
         p2_port_id      <= 8'h00;
         p2_out_port     <= 8'h00;
      end else begin
         case (state_q)
            IDLE: begin
               state_q <= LOAD;
               cnt_q   <= 8'd0;
            end
            LOAD: begin
               if (cnt_q < 8'd8) {v0_q, v1_q} <= {v0_q[23:0], v1_q, ld_byte};
               else              key_q        <= {key_q[119:0], ld_byte};
               if (cnt_q == 8'(LOAD_BYTES - 1)) begin
                  state_q <= ENC;
                  cnt_q   <= 8'd0;
                  sum_q   <= 32'd0;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            ENC: begin
               v0_q  <= v0_d;
               v1_q  <= v1_d;
               sum_q <= sum_d;
               // Byte 0 is issued straight from the final round so WRITE is exactly 8 strobe cycles.
               if (cnt_q == 8'(ROUNDS - 1)) begin
                  state_q         <= WRITE;
                  cnt_q           <= 8'd0;
                  p2_write_strobe <= 1'b1;
                  p2_port_id      <= 8'h00;
                  p2_out_port     <= v0_d[31:24];
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            WRITE: begin
               if (cnt_q == 8'd7) begin
                  state_q         <= DONE;
                  p2_write_strobe <= 1'b0;
               end else begin
                  p2_port_id  <= cnt_q + 8'd1;
                  p2_out_port <= sel_byte({v0_q, v1_q}, cnt_q[2:0] + 3'd1);
                  cnt_q       <= cnt_q + 8'd1;
               end
            end
            default: begin
               p2_write_strobe <= 1'b0;
            end
         endcase
      end
   end

   xtea_byte_ram #(.DEPTH(MEM3_DEPTH)) ram_mem3 (
      .clk    (clk),
      .rst    (rst),
      .we_i   (p2_write_strobe),
      .addr_i (p2_port_id[2:0]),
      .dat_i  (p2_out_port)
   );
endmodule

// File: tb/tb_xtea_system_top.sv
// Bench for xtea_system_top: full 32-round system plus a 1-round instance, checked
// against hand-computed ciphertext through the result RAM and the debug-bus strobes.
module tb_xtea_system_top;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   xtea_system_top #(.ROUNDS(32)) dut  (.clk(clk), .rst(rst));
   xtea_system_top #(.ROUNDS(1))  dut1 (.clk(clk), .rst(rst));

   typedef struct {
      logic [7:0] idx;
      logic [7:0] exp32;
      logic [7:0] exp1;
   } vec_t;
   vec_t vecs [8];

   int n_tests = 0;
   int n_fail  = 0;

   int         pc0 = 0, pc1 = 0;
   logic [7:0] pid0 [8], pd0 [8], pid1 [8], pd1 [8];

   always @(negedge clk or negedge rst) begin
      if (!rst) begin
         pc0 = 0;
         pc1 = 0;
      end else begin
         if (dut.p2_write_strobe) begin
            if (pc0 < 8) begin
               pid0[pc0] = dut.p2_port_id;
               pd0[pc0]  = dut.p2_out_port;
            end
            pc0++;
         end
         if (dut1.p2_write_strobe) begin
            if (pc1 < 8) begin
               pid1[pc1] = dut1.p2_port_id;
               pd1[pc1]  = dut1.p2_out_port;
            end
            pc1++;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic check_cleared(input string tag);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("%s ram32[%0d]", tag, i), 64'(dut.ram_mem3.ram[i]), 64'h0);
         chk($sformatf("%s ram1[%0d]", tag, i), 64'(dut1.ram_mem3.ram[i]), 64'h0);
      end
      chk({tag, " strobe32"}, 64'(dut.p2_write_strobe), 64'h0);
      chk({tag, " strobe1"}, 64'(dut1.p2_write_strobe), 64'h0);
      chk({tag, " port_id32"}, 64'(dut.p2_port_id), 64'h0);
      chk({tag, " out_port32"}, 64'(dut.p2_out_port), 64'h0);
   endtask

   task automatic check_final(input string tag);
      chk({tag, " pulses32"}, 64'(pc0), 64'd8);
      chk({tag, " pulses1"}, 64'(pc1), 64'd8);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("%s ram32[%0d]", tag, i), 64'(dut.ram_mem3.ram[i]), 64'(vecs[i].exp32));
         chk($sformatf("%s ram1[%0d]", tag, i), 64'(dut1.ram_mem3.ram[i]), 64'(vecs[i].exp1));
         chk($sformatf("%s bus32 id[%0d]", tag, i), 64'(pid0[i]), 64'(vecs[i].idx));
         chk($sformatf("%s bus32 dat[%0d]", tag, i), 64'(pd0[i]), 64'(vecs[i].exp32));
         chk($sformatf("%s bus1 id[%0d]", tag, i), 64'(pid1[i]), 64'(vecs[i].idx));
         chk($sformatf("%s bus1 dat[%0d]", tag, i), 64'(pd1[i]), 64'(vecs[i].exp1));
      end
   endtask

   initial begin
      // 32-round: reference ciphertext; 1-round: v0=BB55F40B v1=1705DC5B worked by hand.
      vecs[0] = '{8'h00, 8'hC3, 8'hBB};
      vecs[1] = '{8'h01, 8'hB9, 8'h55};
      vecs[2] = '{8'h02, 8'h0E, 8'hF4};
      vecs[3] = '{8'h03, 8'hB5, 8'h0B};
      vecs[4] = '{8'h04, 8'h22, 8'h17};
      vecs[5] = '{8'h05, 8'h56, 8'h05};
      vecs[6] = '{8'h06, 8'hFE, 8'hDC};
      vecs[7] = '{8'h07, 8'h61, 8'h5B};

      #50;
      check_cleared("in_reset");
      #50;
      rst = 1'b1;

      // 1+24+32+8 edges bound the last write of the full-round instance.
      repeat (66) @(posedge clk);
      @(negedge clk);
      chk("latency pulses32", 64'(pc0), 64'd8);
      chk("latency pulses1", 64'(pc1), 64'd8);

      repeat (200) @(posedge clk);
      @(negedge clk);
      check_final("run1");

      // Async assertion between edges must clear state without a clock edge.
      @(posedge clk);
      #3 rst = 1'b0;
      #1 check_cleared("async_done");
      #36 rst = 1'b1;

      // Abort the full-round instance mid-encryption.
      repeat (40) @(posedge clk);
      #2;
      chk("pulses before midenc reset", 64'(pc0), 64'd0);
      rst = 1'b0;
      #1 check_cleared("midenc");
      #22 rst = 1'b1;

      repeat (200) @(posedge clk);
      @(negedge clk);
      check_final("rerun");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
